// File: rtl/map_update_pkg.sv
// Shared definitions for the tile-map read-modify-write engine.
//   - op codes carried with each request
//   - FSM state encoding used by map_updater
//   - field widths of the queued request record {x, y, op, tile, match}
package map_update_pkg;

  localparam int COORD_W = 4;
  localparam int OP_W    = 2;

  localparam logic [OP_W-1:0] OP_WRITE    = 2'd0;
  localparam logic [OP_W-1:0] OP_CLEAR_IF = 2'd1;
  localparam logic [OP_W-1:0] OP_PROBE    = 2'd2;  // code 3 behaves the same

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_CAPT,
    ST_DECIDE,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Width of one queued request for a given tile-id width.
  function automatic int req_rec_w(input int data_w);
    return 2 * COORD_W + OP_W + 2 * data_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with full/empty flags.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write request and data; ignored while full
//   pop         : read request; ignored while empty
//   dout        : head entry, valid whenever empty is low
//   full, empty : occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/map_updater.sv
// Read-modify-write engine for the tile-map BRAM port B.
// Requests from the player are queued, then each one is executed as
// read -> compare -> optional write, ending in a one-cycle done pulse.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready = queue not full)
//   req_x, req_y, req_op         : tile coordinates and operation
//   req_tile, req_match          : write value and compare value
//   bram_req/bram_gnt            : port B arbitration
//   bram_addr/din/we, bram_dout  : port B access; dout is one cycle after
//                                  the address is presented under grant
//   done, done_hit, done_err,
//   done_old                     : completion pulse and status
//   busy                         : queue non-empty or request in flight
module map_updater
  import map_update_pkg::*;
#(
  parameter int MAP_WIDTH  = 16,
  parameter int MAP_HEIGHT = 16,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int QDEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic [OP_W-1:0]    req_op,
  input  logic [DATA_W-1:0]  req_tile,
  input  logic [DATA_W-1:0]  req_match,
  output logic               bram_req,
  input  logic               bram_gnt,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic [DATA_W-1:0]  bram_din,
  output logic               bram_we,
  input  logic [DATA_W-1:0]  bram_dout,
  output logic               done,
  output logic               done_hit,
  output logic               done_err,
  output logic [DATA_W-1:0]  done_old,
  output logic               busy
);

  localparam int REQ_W = req_rec_w(DATA_W);

  // request queue
  logic [REQ_W-1:0]   fifo_din, fifo_dout;
  logic               fifo_full, fifo_empty, pop;
  logic [COORD_W-1:0] h_x, h_y;
  logic [OP_W-1:0]    h_op;
  logic [DATA_W-1:0]  h_tile, h_match;

  assign fifo_din = {req_x, req_y, req_op, req_tile, req_match};
  assign {h_x, h_y, h_op, h_tile, h_match} = fifo_dout;

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // working request and FSM state
  state_t             state;
  logic [COORD_W-1:0] w_x, w_y;
  logic [OP_W-1:0]    w_op;
  logic [DATA_W-1:0]  w_tile, w_match, old_q;
  logic               we_q;
  logic               oob, hit;
  logic [ADDR_W-1:0]  addr_calc;

  // DONE also pops, so a queued request starts without an IDLE bubble:
  // back-to-back cost is 6 cycles on a hit and 5 on a miss.
  assign pop = ((state == ST_IDLE) || (state == ST_DONE)) && !fifo_empty;

  assign oob       = (32'(w_x) >= MAP_WIDTH) || (32'(w_y) >= MAP_HEIGHT);
  assign addr_calc = ADDR_W'(w_y) * ADDR_W'(MAP_WIDTH) + ADDR_W'(w_x);
  assign hit       = (w_op == OP_WRITE) || ((w_op == OP_CLEAR_IF) && (old_q == w_match));

  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);
  // Write strobe is gated by the live grant so it can never fire without it.
  assign bram_we   = we_q && bram_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      w_x       <= '0;
      w_y       <= '0;
      w_op      <= '0;
      w_tile    <= '0;
      w_match   <= '0;
      old_q     <= '0;
      we_q      <= 1'b0;
      bram_req  <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      done      <= 1'b0;
      done_hit  <= 1'b0;
      done_err  <= 1'b0;
      done_old  <= '0;
    end else begin
      done <= 1'b0;
      if (pop) begin
        w_x     <= h_x;
        w_y     <= h_y;
        w_op    <= h_op;
        w_tile  <= h_tile;
        w_match <= h_match;
      end
      case (state)
        ST_IDLE: if (pop) state <= ST_CHECK;
        ST_CHECK: begin
          if (oob) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            done_hit <= 1'b0;
            done_err <= 1'b1;
            done_old <= '0;
          end else begin
            state     <= ST_READ;
            bram_req  <= 1'b1;
            bram_addr <= addr_calc;
          end
        end
        ST_READ: if (bram_gnt) state <= ST_CAPT;
        // Losing the grant anywhere between read and write restarts the
        // read so the decision is never made on data someone else changed.
        ST_CAPT: begin
          if (bram_gnt) begin
            old_q <= bram_dout;
            state <= ST_DECIDE;
          end else begin
            state <= ST_READ;
          end
        end
        ST_DECIDE: begin
          if (!bram_gnt) begin
            state <= ST_READ;
          end else if (hit) begin
            state    <= ST_WRITE;
            we_q     <= 1'b1;
            bram_din <= w_tile;
          end else begin
            state    <= ST_DONE;
            bram_req <= 1'b0;
            done     <= 1'b1;
            done_hit <= 1'b0;
            done_err <= 1'b0;
            done_old <= old_q;
          end
        end
        ST_WRITE: begin
          if (bram_gnt) begin
            state    <= ST_DONE;
            we_q     <= 1'b0;
            bram_req <= 1'b0;
            done     <= 1'b1;
            done_hit <= 1'b1;
            done_err <= 1'b0;
            done_old <= old_q;
          end
        end
        ST_DONE: state <= pop ? ST_CHECK : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_updater.sv
// Scoreboard bench for map_updater. The driver pushes the hand-computed
// response (and write, for hits) of each accepted request; the monitor pops
// and compares whenever done or bram_we is presented.
// Memory starts as mem[a] = 0x0100 + a. Coordinates are 4 bits wide, so
// MAP_HEIGHT is set to 12 here to make an out-of-range row reachable.
module tb_map_updater;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_x, req_y;
  logic [1:0]  req_op;
  logic [15:0] req_tile, req_match;
  logic        bram_req, bram_gnt, bram_we;
  logic [18:0] bram_addr;
  logic [15:0] bram_din, bram_dout;
  logic        done, done_hit, done_err, busy;
  logic [15:0] done_old;

  map_updater #(
    .MAP_WIDTH(16), .MAP_HEIGHT(12), .ADDR_W(19), .DATA_W(16), .QDEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .req_tile(req_tile), .req_match(req_match),
    .bram_req(bram_req), .bram_gnt(bram_gnt),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_dout(bram_dout),
    .done(done), .done_hit(done_hit), .done_err(done_err),
    .done_old(done_old), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // port B model: read-first, one cycle read latency
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
  always @(posedge clk) begin
    if (bram_req && bram_gnt) begin
      bram_dout <= mem[bram_addr[7:0]];
      if (bram_we) mem[bram_addr[7:0]] = bram_din;
    end
  end

  typedef struct { logic hit; logic err; logic [15:0] old; int acc; int lat; } done_exp_t;
  typedef struct { logic [18:0] addr; logic [15:0] din; int acc; int lat; } wr_exp_t;

  done_exp_t dq[$];
  wr_exp_t   wq[$];
  done_exp_t md;
  wr_exp_t   mw;
  int checks = 0;
  int errors = 0;
  int last_acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // monitor: samples 2 time units after the active edge
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (bram_we) begin
        chk("we_without_gnt", 32'(bram_gnt), 1);
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mw = wq.pop_front();
          chk("wr_addr", 32'(bram_addr), 32'(mw.addr));
          chk("wr_din", 32'(bram_din), 32'(mw.din));
          if (mw.lat >= 0) chk("wr_latency", cyc - mw.acc, mw.lat);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          md = dq.pop_front();
          chk("done_hit", 32'(done_hit), 32'(md.hit));
          chk("done_err", 32'(done_err), 32'(md.err));
          chk("done_old", 32'(done_old), 32'(md.old));
          if (md.lat >= 0) chk("done_latency", cyc - md.acc, md.lat);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op,
                      input logic [15:0] tile, input logic [15:0] match,
                      input logic e_hit, input logic e_err, input logic [15:0] e_old,
                      input logic [18:0] e_addr, input int dlat, input int wlat);
    int n = 0;
    done_exp_t d;
    wr_exp_t   w;
    req_valid = 1'b1; req_x = x; req_y = y; req_op = op;
    req_tile = tile; req_match = match;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      last_acc = cyc;
      d.hit = e_hit; d.err = e_err; d.old = e_old; d.acc = cyc; d.lat = dlat;
      dq.push_back(d);
      if (e_hit) begin
        w.addr = e_addr; w.din = tile; w.acc = cyc; w.lat = wlat;
        wq.push_back(w);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || dq.size() != 0 || wq.size() != 0) && n < 400) begin
      @(negedge clk); n++;
    end
    if (n >= 400) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_op = '0;
    req_tile = '0; req_match = '0; bram_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bram_req", 32'(bram_req), 0);
    chk("rst_bram_we", 32'(bram_we), 0);
    chk("rst_bram_addr", 32'(bram_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // WRITE (3,2): addr 35, we at T+5, done at T+6
    send(4'd3, 4'd2, 2'd0, 16'h0005, 16'h0000, 1, 0, 16'h0123, 19'd35, 6, 5);
    wait_idle();
    // two hits back to back: second one completes 6 cycles after the first
    send(4'd2, 4'd0, 2'd0, 16'h0022, 16'h0000, 1, 0, 16'h0102, 19'd2, 6, 5);
    send(4'd4, 4'd0, 2'd0, 16'h0044, 16'h0000, 1, 0, 16'h0104, 19'd4, 11, 10);
    wait_idle();

    // CLEAR_IF at (1,1), addr 17
    send(4'd1, 4'd1, 2'd0, 16'h0007, 16'h0000, 1, 0, 16'h0111, 19'd17, 6, 5);
    wait_idle();
    send(4'd1, 4'd1, 2'd1, 16'h0000, 16'h0007, 1, 0, 16'h0007, 19'd17, 6, 5);
    wait_idle();
    send(4'd1, 4'd1, 2'd0, 16'h0003, 16'h0000, 1, 0, 16'h0000, 19'd17, 6, 5);
    wait_idle();
    send(4'd1, 4'd1, 2'd1, 16'h0000, 16'h0007, 0, 0, 16'h0003, 19'd17, 5, -1);
    wait_idle();

    // PROBE at last in-range tile, reserved op with a matching compare value
    send(4'd15, 4'd11, 2'd2, 16'hBEEF, 16'h01BF, 0, 0, 16'h01BF, 19'd191, 5, -1);
    wait_idle();
    send(4'd0, 4'd0, 2'd3, 16'hFFFF, 16'h0100, 0, 0, 16'h0100, 19'd0, 5, -1);
    wait_idle();

    // out-of-range row: error status, no port access
    send(4'd15, 4'd12, 2'd1, 16'h0000, 16'h0000, 0, 1, 16'h0000, 19'd0, -1, -1);
    seen = 0;
    repeat (5) begin seen += int'(bram_req); @(negedge clk); end
    chk("oob_no_bram_req", seen, 0);
    wait_idle();

    // grant withheld: the first request sits in the working register, so the
    // FIFO fills on the fifth accepted request
    bram_gnt = 1'b0;
    send(4'd0, 4'd5, 2'd0, 16'hA000, 16'h0, 1, 0, 16'h0150, 19'd80, -1, -1);
    send(4'd1, 4'd5, 2'd0, 16'hA001, 16'h0, 1, 0, 16'h0151, 19'd81, -1, -1);
    send(4'd2, 4'd5, 2'd0, 16'hA002, 16'h0, 1, 0, 16'h0152, 19'd82, -1, -1);
    send(4'd3, 4'd5, 2'd0, 16'hA003, 16'h0, 1, 0, 16'h0153, 19'd83, -1, -1);
    chk("ready_with_3_queued", 32'(req_ready), 1);
    send(4'd4, 4'd5, 2'd0, 16'hA004, 16'h0, 1, 0, 16'h0154, 19'd84, -1, -1);
    chk("ready_when_full", 32'(req_ready), 0);
    chk("no_done_without_gnt", 32'(done), 0);
    fork
      begin repeat (3) @(negedge clk); bram_gnt = 1'b1; end
      send(4'd5, 4'd5, 2'd0, 16'hA005, 16'h0, 1, 0, 16'h0155, 19'd85, -1, -1);
    join
    wait_idle();

    // grant lost during DECIDE: re-read, then write
    send(4'd7, 4'd3, 2'd0, 16'h0BEE, 16'h0, 1, 0, 16'h0137, 19'd55, 9, 8);
    repeat (4) @(negedge clk);
    bram_gnt = 1'b0;
    chk("drop_gnt_we", 32'(bram_we), 0);
    @(negedge clk);
    chk("reread_bram_req", 32'(bram_req), 1);
    bram_gnt = 1'b1;
    wait_idle();

    // reset in WRITE with two requests still queued
    send(4'd8, 4'd8, 2'd0, 16'h00AA, 16'h0, 1, 0, 16'h0188, 19'd136, 6, 5);
    send(4'd9, 4'd8, 2'd0, 16'h00BB, 16'h0, 1, 0, 16'h0189, 19'd137, -1, -1);
    send(4'd10, 4'd8, 2'd0, 16'h00CC, 16'h0, 1, 0, 16'h018A, 19'd138, -1, -1);
    repeat (3) @(negedge clk);
    chk("in_write_we", 32'(bram_we), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_bram_req", 32'(bram_req), 0);
    chk("post_rst_bram_we", 32'(bram_we), 0);
    chk("post_rst_done", 32'(done), 0);
    dq.delete();
    wq.delete();
    rst = 1'b0;
    seen = 0;
    repeat (15) begin @(negedge clk); seen += int'(done) + int'(bram_we) + int'(bram_req); end
    chk("quiet_after_rst", seen, 0);
    send(4'd9, 4'd9, 2'd0, 16'h1234, 16'h0, 1, 0, 16'h0199, 19'd153, 6, 5);
    wait_idle();

    chk("mem_35", 32'(mem[35]), 32'h0005);
    chk("mem_17", 32'(mem[17]), 32'h0003);
    chk("mem_85", 32'(mem[85]), 32'hA005);
    chk("mem_55", 32'(mem[55]), 32'h0BEE);
    chk("mem_137_dropped", 32'(mem[137]), 32'h0189);
    chk("mem_153", 32'(mem[153]), 32'h1234);
    chk("done_queue_empty", dq.size(), 0);
    chk("write_queue_empty", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
